// File: rtl/dca_mru_step_pkg.sv
// dca_mru_step_pkg: shared mode encodings, step field layout and width helpers for the MRU step sequencer
package dca_mru_step_pkg;
  typedef enum logic [1:0] {
    MODE_PASS      = 2'd0,
    MODE_TRANSPOSE = 2'd1,
    MODE_FILL      = 2'd2,
    MODE_ZERO      = 2'd3
  } mode_e;
  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;
  localparam int MODE_LSB = 0;
  localparam int MODE_W = 2;
  localparam int SEL_LSB = MODE_LSB + MODE_W;
  function automatic int sel_width(input int num_lsu);
    return num_lsu > 1 ? $clog2(num_lsu) : 1;
  endfunction
  function automatic int step_width(input int num_lsu);
    return sel_width(num_lsu) + 4;
  endfunction
  function automatic int req_pos(input int num_lsu);
    return SEL_LSB + sel_width(num_lsu);
  endfunction
  function automatic int last_pos(input int num_lsu);
    return req_pos(num_lsu) + 1;
  endfunction
endpackage

// File: rtl/dca_mru_matrix_xform.sv
// dca_mru_matrix_xform: combinational pass/transpose/fill/zero of an N x N row-major matrix
module dca_mru_matrix_xform
  import dca_mru_step_pkg::*;
#(
  parameter int N  = 4,
  parameter int BW = 16
) (
  input  logic [1:0]          mode,
  input  logic [N*N*BW-1:0]   src,
  input  logic [BW-1:0]       fill_value,
  output logic [N*N*BW-1:0]   result
);
  for (genvar r = 0; r < N; r++) begin : g_row
    for (genvar c = 0; c < N; c++) begin : g_col
      assign result[(r*N+c)*BW +: BW] =
        mode == MODE_PASS      ? src[(r*N+c)*BW +: BW] :
        mode == MODE_TRANSPOSE ? src[(c*N+r)*BW +: BW] :
        mode == MODE_FILL      ? fill_value : '0;
    end
  end
endmodule

// File: rtl/dca_mru_step_sequencer.sv
// dca_mru_step_sequencer: MRU step controller with LSU/fill arbitration, registered write stage and credit-tracked drain
module dca_mru_step_sequencer
  import dca_mru_step_pkg::*;
#(
  parameter int MATRIX_SIZE  = 4,
  parameter int BW_SCALAR    = 16,
  parameter int NUM_LSU      = 2,
  parameter int CREDIT_DEPTH = 4,
  localparam int NUM_ELEM  = MATRIX_SIZE * MATRIX_SIZE,
  localparam int BW_MATRIX = NUM_ELEM * BW_SCALAR,
  localparam int BW_SEL    = sel_width(NUM_LSU),
  localparam int BW_STEP   = step_width(NUM_LSU),
  localparam int BW_CNT    = $clog2(CREDIT_DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rstnn,
  input  logic                         clear,
  input  logic                         step_valid,
  input  logic [BW_STEP-1:0]           step_inst,
  output logic                         step_ready,
  input  logic                         fill_valid,
  input  logic [BW_SCALAR-1:0]         fill_value,
  output logic                         fill_ready,
  output logic [NUM_LSU-1:0]           lsu_req,
  input  logic [NUM_LSU-1:0]           lsu_ready,
  input  logic [NUM_LSU*BW_MATRIX-1:0] lsu_matrix,
  output logic                         mreg_wvalid,
  input  logic                         mreg_wready,
  output logic [NUM_ELEM-1:0]          mreg_wenable,
  output logic [BW_MATRIX-1:0]         mreg_wdata,
  input  logic                         credit_ret,
  output logic                         busy,
  output logic                         done,
  output logic                         credit_err
);
  localparam logic [BW_CNT-1:0] CNT_MAX = BW_CNT'(CREDIT_DEPTH);
  localparam logic [BW_CNT-1:0] CNT_ONE = BW_CNT'(1);
  state_e              state, state_nxt;
  logic                armed;
  logic [BW_CNT-1:0]   cnt, cnt_nxt;
  logic                inst_last, inst_req;
  logic [BW_SEL-1:0]   sel_raw, sel;
  logic [1:0]          mode;
  logic [BW_MATRIX-1:0] src, result;
  logic                lsu_ok, fill_ok, cnt_ok, out_ok, run, fire;
  assign inst_last = step_inst[last_pos(NUM_LSU)];
  assign inst_req  = step_inst[req_pos(NUM_LSU)];
  assign sel_raw   = step_inst[SEL_LSB +: BW_SEL];
  assign mode      = step_inst[MODE_LSB +: MODE_W];
  assign sel       = int'(sel_raw) < NUM_LSU ? sel_raw : '0;
  assign src       = inst_req ? lsu_matrix[int'(sel)*BW_MATRIX +: BW_MATRIX] : '0;
  assign lsu_ok    = !inst_req | lsu_ready[sel];
  assign fill_ok   = mode != MODE_FILL | fill_valid;
  assign cnt_ok    = cnt < CNT_MAX | credit_ret;
  assign out_ok    = !mreg_wvalid | mreg_wready;
  dca_mru_matrix_xform #(
    .N (MATRIX_SIZE),
    .BW(BW_SCALAR)
  ) u_xform (
    .mode      (mode),
    .src       (src),
    .fill_value(fill_value),
    .result    (result)
  );
  // armed drops asynchronously with rstnn so every combinational output is quiet during reset
  always_ff @(posedge clk or negedge rstnn)
    if (!rstnn) begin
      armed <= 1'b0;
      state <= ST_RUN;
    end else begin
      armed <= 1'b1;
      state <= state_nxt;
    end
  always_comb
    state_nxt = clear ? ST_RUN :
                state == ST_RUN ? (fire & inst_last ? ST_DRAIN : ST_RUN) :
                done ? ST_RUN : ST_DRAIN;
  always_comb begin
    run        = armed & !clear & state == ST_RUN;
    fire       = run & step_valid & lsu_ok & fill_ok & cnt_ok & out_ok;
    done       = !clear & state == ST_DRAIN & (cnt == '0 | (cnt == CNT_ONE & credit_ret));
    step_ready = fire;
    fill_ready = fire & mode == MODE_FILL;
    lsu_req    = fire & inst_req ? NUM_LSU'(1) << sel : '0;
    busy       = armed & (step_valid | state == ST_DRAIN | cnt != '0 | mreg_wvalid);
  end
  always_comb
    cnt_nxt = clear ? '0 :
              fire & !credit_ret ? cnt + CNT_ONE :
              !fire & credit_ret & cnt != '0 ? cnt - CNT_ONE : cnt;
  assign mreg_wenable = {NUM_ELEM{mreg_wvalid}};
  always_ff @(posedge clk or negedge rstnn)
    if (!rstnn) begin
      cnt         <= '0;
      credit_err  <= 1'b0;
      mreg_wvalid <= 1'b0;
      mreg_wdata  <= '0;
    end else begin
      cnt         <= cnt_nxt;
      credit_err  <= !clear & (credit_err | (credit_ret & cnt == '0));
      mreg_wvalid <= !clear & (fire | (mreg_wvalid & !mreg_wready));
      mreg_wdata  <= clear ? '0 : fire ? result : mreg_wdata;
    end
endmodule

// File: tb/tb_dca_mru_step_sequencer.sv
// tb_dca_mru_step_sequencer: table-driven and scoreboard-checked bench for the MRU step sequencer
module tb_dca_mru_step_sequencer;
  logic        clk = 1'b0, rstnn = 1'b0, clear = 1'b0, step_valid = 1'b0, fill_valid = 1'b0;
  logic        mreg_wready = 1'b0, credit_ret = 1'b0;
  logic [4:0]  step_inst = '0;
  logic [7:0]  fill_value = '0;
  logic [1:0]  lsu_ready = '0;
  logic [63:0] lsu_matrix = '0;
  logic        step_ready, fill_ready, mreg_wvalid, busy, done, credit_err;
  logic [1:0]  lsu_req;
  logic [3:0]  mreg_wenable;
  logic [31:0] mreg_wdata;
  int          checks = 0, failures = 0;
  logic [31:0] sb[$];
  typedef struct {
    logic [4:0]  inst;
    logic [1:0]  req;
    logic        fr;
    logic [31:0] data;
  } vec_t;
  vec_t vecs[8];
  localparam logic [4:0] PASS1 = 5'b01100, TR1 = 5'b01101, PASS0 = 5'b01000, TR0 = 5'b01001;
  localparam logic [4:0] FILL = 5'b00010, FILL_REQ0 = 5'b01010, ZERO1 = 5'b01111, PASS_NR = 5'b00000;
  localparam logic [4:0] LAST1 = 5'b11100, LAST0 = 5'b11000;

  dca_mru_step_sequencer #(
    .MATRIX_SIZE(2), .BW_SCALAR(8), .NUM_LSU(2), .CREDIT_DEPTH(4)
  ) dut (
    .clk(clk), .rstnn(rstnn), .clear(clear), .step_valid(step_valid), .step_inst(step_inst),
    .step_ready(step_ready), .fill_valid(fill_valid), .fill_value(fill_value), .fill_ready(fill_ready),
    .lsu_req(lsu_req), .lsu_ready(lsu_ready), .lsu_matrix(lsu_matrix), .mreg_wvalid(mreg_wvalid),
    .mreg_wready(mreg_wready), .mreg_wenable(mreg_wenable), .mreg_wdata(mreg_wdata),
    .credit_ret(credit_ret), .busy(busy), .done(done), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk)
    if (rstnn && mreg_wvalid && mreg_wready) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write: got %0h expected none", mreg_wdata);
      end else begin
        chk("wdata", {32'd0, mreg_wdata}, {32'd0, sb.pop_front()});
        chk("wenable", {60'd0, mreg_wenable}, 64'hf);
      end
    end

  task automatic do_step(input logic [4:0] inst, input logic [31:0] exp_d,
                         input logic [1:0] exp_req, input logic exp_fr, input string nm);
    int w = 0;
    step_inst  = inst;
    step_valid = 1'b1;
    @(negedge clk);
    while (!step_ready && w < 20) begin
      w++;
      @(negedge clk);
    end
    chk({nm, "_fire"}, {63'd0, step_ready}, 64'd1);
    if (step_ready) begin
      chk({nm, "_lsu_req"}, {62'd0, lsu_req}, {62'd0, exp_req});
      chk({nm, "_fill_ready"}, {63'd0, fill_ready}, {63'd0, exp_fr});
      sb.push_back(exp_d);
    end
    @(posedge clk);
    #1;
    step_valid = 1'b0;
    step_inst  = '0;
  endtask

  task automatic ret_credit(input int n);
    credit_ret = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    credit_ret = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{PASS1,     2'b10, 1'b0, 32'h01020304};
    vecs[1] = '{TR1,       2'b10, 1'b0, 32'h01030204};
    vecs[2] = '{PASS0,     2'b01, 1'b0, 32'h11223344};
    vecs[3] = '{TR0,       2'b01, 1'b0, 32'h11332244};
    vecs[4] = '{FILL,      2'b00, 1'b1, 32'h5a5a5a5a};
    vecs[5] = '{FILL_REQ0, 2'b01, 1'b1, 32'h5a5a5a5a};
    vecs[6] = '{ZERO1,     2'b10, 1'b0, 32'h00000000};
    vecs[7] = '{PASS_NR,   2'b00, 1'b0, 32'h00000000};
    lsu_matrix  = {32'h01020304, 32'h11223344};
    lsu_ready   = 2'b11;
    fill_value  = 8'h5a;
    fill_valid  = 1'b1;
    mreg_wready = 1'b1;
    step_valid  = 1'b1;
    step_inst   = PASS1;
    #12;
    chk("rst_step_ready", {63'd0, step_ready}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_wvalid", {63'd0, mreg_wvalid}, 64'd0);
    chk("rst_wdata", {32'd0, mreg_wdata}, 64'd0);
    chk("rst_wenable", {60'd0, mreg_wenable}, 64'd0);
    chk("rst_lsu_req", {62'd0, lsu_req}, 64'd0);
    chk("rst_fill_ready", {63'd0, fill_ready}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_credit_err", {63'd0, credit_err}, 64'd0);
    @(posedge clk);
    #1;
    rstnn = 1'b1;
    step_valid = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      do_step(vecs[i].inst, vecs[i].data, vecs[i].req, vecs[i].fr, $sformatf("vec%0d", i));
      ret_credit(1);
    end
    fill_valid = 1'b0;
    step_inst  = FILL;
    step_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("fill_stall_ready", {63'd0, step_ready}, 64'd0);
      chk("fill_stall_fill_ready", {63'd0, fill_ready}, 64'd0);
    end
    @(posedge clk);
    #1;
    fill_valid = 1'b1;
    do_step(FILL, 32'h5a5a5a5a, 2'b00, 1'b1, "fill_release");
    ret_credit(1);
    for (int i = 0; i < 4; i++) do_step(PASS1, 32'h01020304, 2'b10, 1'b0, $sformatf("credit%0d", i));
    step_inst  = PASS0;
    step_valid = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("credit_full_stall", {63'd0, step_ready}, 64'd0);
    end
    @(posedge clk);
    #1;
    credit_ret = 1'b1;
    @(negedge clk);
    chk("credit_ret_fire", {63'd0, step_ready}, 64'd1);
    if (step_ready) sb.push_back(32'h11223344);
    @(posedge clk);
    #1;
    credit_ret = 1'b0;
    @(negedge clk);
    chk("credit_still_full", {63'd0, step_ready}, 64'd0);
    @(posedge clk);
    #1;
    step_valid = 1'b0;
    ret_credit(3);
    @(negedge clk);
    chk("credit_three_back_busy", {63'd0, busy}, 64'd1);
    @(posedge clk);
    #1;
    ret_credit(1);
    @(negedge clk);
    chk("credit_drained_busy", {63'd0, busy}, 64'd0);
    @(posedge clk);
    #1;
    mreg_wready = 1'b0;
    do_step(PASS0, 32'h11223344, 2'b01, 1'b0, "hold_a");
    step_inst  = TR1;
    step_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("hold_ready", {63'd0, step_ready}, 64'd0);
      chk("hold_wvalid", {63'd0, mreg_wvalid}, 64'd1);
      chk("hold_wdata", {32'd0, mreg_wdata}, 64'h11223344);
    end
    @(posedge clk);
    #1;
    mreg_wready = 1'b1;
    @(negedge clk);
    chk("hold_release_fire", {63'd0, step_ready}, 64'd1);
    if (step_ready) sb.push_back(32'h01030204);
    @(posedge clk);
    #1;
    step_valid = 1'b0;
    ret_credit(2);
    do_step(PASS0, 32'h11223344, 2'b01, 1'b0, "drain_first");
    do_step(LAST1, 32'h01020304, 2'b10, 1'b0, "drain_last");
    step_inst  = PASS1;
    step_valid = 1'b1;
    @(negedge clk);
    chk("drain_ready", {63'd0, step_ready}, 64'd0);
    chk("drain_lsu_req", {62'd0, lsu_req}, 64'd0);
    chk("drain_done_early", {63'd0, done}, 64'd0);
    chk("drain_busy", {63'd0, busy}, 64'd1);
    @(posedge clk);
    #1;
    step_valid = 1'b0;
    credit_ret = 1'b1;
    @(negedge clk);
    chk("drain_done_first_ret", {63'd0, done}, 64'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("drain_done_pulse", {63'd0, done}, 64'd1);
    @(posedge clk);
    #1;
    credit_ret = 1'b0;
    @(negedge clk);
    chk("drain_done_after", {63'd0, done}, 64'd0);
    chk("drain_busy_after", {63'd0, busy}, 64'd0);
    @(posedge clk);
    #1;
    do_step(PASS1, 32'h01020304, 2'b10, 1'b0, "run_again");
    ret_credit(1);
    ret_credit(1);
    @(negedge clk);
    chk("err_set", {63'd0, credit_err}, 64'd1);
    chk("err_cnt_zero_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    chk("err_sticky", {63'd0, credit_err}, 64'd1);
    @(posedge clk);
    #1;
    clear = 1'b1;
    step_inst  = PASS1;
    step_valid = 1'b1;
    @(negedge clk);
    chk("clear_blocks_fire", {63'd0, step_ready}, 64'd0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    step_valid = 1'b0;
    @(negedge clk);
    chk("clear_err", {63'd0, credit_err}, 64'd0);
    @(posedge clk);
    #1;
    do_step(LAST0, 32'h11223344, 2'b01, 1'b0, "clear_drain");
    clear = 1'b1;
    credit_ret = 1'b1;
    @(negedge clk);
    chk("clear_drain_done", {63'd0, done}, 64'd0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    credit_ret = 1'b0;
    @(negedge clk);
    chk("clear_drain_busy", {63'd0, busy}, 64'd0);
    chk("clear_drain_done_after", {63'd0, done}, 64'd0);
    @(posedge clk);
    #1;
    mreg_wready = 1'b0;
    do_step(LAST1, 32'h01020304, 2'b10, 1'b0, "rst_drain");
    step_inst  = FILL;
    step_valid = 1'b1;
    @(negedge clk);
    chk("rst_drain_wvalid_pre", {63'd0, mreg_wvalid}, 64'd1);
    #2;
    rstnn = 1'b0;
    #1;
    chk("arst_step_ready", {63'd0, step_ready}, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_wvalid", {63'd0, mreg_wvalid}, 64'd0);
    chk("arst_wdata", {32'd0, mreg_wdata}, 64'd0);
    chk("arst_wenable", {60'd0, mreg_wenable}, 64'd0);
    chk("arst_done", {63'd0, done}, 64'd0);
    chk("arst_fill_ready", {63'd0, fill_ready}, 64'd0);
    chk("arst_lsu_req", {62'd0, lsu_req}, 64'd0);
    sb.delete();
    @(posedge clk);
    #1;
    rstnn = 1'b1;
    step_valid = 1'b0;
    mreg_wready = 1'b1;
    do_step(TR0, 32'h11332244, 2'b01, 1'b0, "post_reset");
    ret_credit(1);
    @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
